// File: rtl/noc_local_packetizer_pkg.sv
// Shared constants, FSM state type and head-flit layout for the NI packetizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package noc_ni_pkg;

  localparam int FLIT_W  = 8;
  localparam int DST_W   = 4;
  localparam int MAX_LEN = 4;
  localparam int CREDITS = 4;
  localparam int LEN_W   = 3;

  // Head flit layout for 8-bit flits: {dst[3:0], head marker, len[2:0]}
  localparam int DST_MSB  = 7;
  localparam int DST_LSB  = 4;
  localparam int HEAD_BIT = 3;
  localparam int LEN_MSB  = 2;
  localparam int LEN_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } ni_state_t;

  // Clamp a requested payload length to the largest packet the NI emits.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/noc_local_packetizer_if.sv
// Core-side descriptor/payload handshakes plus router-side flit/credit link.
// Latency: n/a (wires only).
// Backpressure: pkt_ready / pl_ready from the packetizer; credit_in from the router.
interface noc_local_packetizer_if #(
  parameter int FLIT_W = noc_ni_pkg::FLIT_W,
  parameter int DST_W  = noc_ni_pkg::DST_W
);

  logic              pkt_valid;
  logic              pkt_ready;
  logic [DST_W-1:0]  pkt_dst;
  logic [2:0]        pkt_len;

  logic              pl_valid;
  logic              pl_ready;
  logic [FLIT_W-1:0] pl_data;

  logic [FLIT_W-1:0] flit_out;
  logic              flit_write;
  logic              credit_in;
  logic              busy;
`ifdef NI_PKT_CNT_EN
  logic [15:0]       pkt_count;
`endif

  // Packetizer side
  modport slave (
    input  pkt_valid, pkt_dst, pkt_len, pl_valid, pl_data, credit_in,
    output pkt_ready, pl_ready, flit_out, flit_write, busy
`ifdef NI_PKT_CNT_EN
    , output pkt_count
`endif
  );

  // Core + router side
  modport master (
    output pkt_valid, pkt_dst, pkt_len, pl_valid, pl_data, credit_in,
    input  pkt_ready, pl_ready, flit_out, flit_write, busy
`ifdef NI_PKT_CNT_EN
    , input pkt_count
`endif
  );

endinterface

// File: rtl/noc_local_packetizer_credit.sv
// Credit counter tracking free slots in a downstream FIFO (reusable per link).
// Latency: count updates on the clock after issue / credit_in.
// Backpressure: has_credit low at zero; caller must gate issue with it.
module ni_credit_counter #(
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             credit_in,
  output logic             has_credit,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

  // Issue consumes a slot, credit_in returns one; both together cancel, surplus returns saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= FULL;
    end else if (issue && !credit_in) begin
      count <= count - 1'b1;
    end else if (!issue && credit_in && (count != FULL)) begin
      count <= count + 1'b1;
    end
  end

  assign has_credit = (count != '0);

endmodule

// File: rtl/noc_local_packetizer.sv
// Local-port NI: descriptor + payload words -> head flit + body flits into router FIFO; NI_PKT_CNT_EN adds pkt_count.
// Latency: flit_write/flit_out one cycle after the handshake or head issue; IDLE->HEAD costs one cycle per packet.
// Backpressure: no flit issued without a credit; pl_ready follows credit availability in BODY only.
module noc_local_packetizer #(
  parameter int FLIT_W  = noc_ni_pkg::FLIT_W,
  parameter int DST_W   = noc_ni_pkg::DST_W,
  parameter int MAX_LEN = noc_ni_pkg::MAX_LEN,
  parameter int CREDITS = noc_ni_pkg::CREDITS
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_local_packetizer_if.slave bus
);

  import noc_ni_pkg::*;

  localparam int               CNT_W     = $clog2(CREDITS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  ni_state_t         state;
  ni_state_t         state_nxt;
  logic [DST_W-1:0]  dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_eff;
  logic [FLIT_W-1:0] head_flit;
  logic              issue_head;
  logic              issue_body;
  logic              issue;
  logic              has_credit;
  logic [CNT_W-1:0]  credit_cnt;

  assign len_eff = clamp_len(bus.pkt_len, MAX_LEN_L);
  assign issue   = issue_head | issue_body;

  ni_credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .credit_in  (bus.credit_in),
    .has_credit (has_credit),
    .count      (credit_cnt)
  );

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: head waits for a credit, body ends on the last accepted word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.pkt_valid) state_nxt = HEAD;
      HEAD: if (has_credit)    state_nxt = (len_q != '0) ? BODY : IDLE;
      BODY: if (issue_body && (remaining == LEN_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and issue strobes decoded from state and credit availability.
  always_comb begin
    bus.pkt_ready = 1'b0;
    bus.pl_ready  = 1'b0;
    bus.busy      = 1'b1;
    issue_head    = 1'b0;
    issue_body    = 1'b0;
    case (state)
      IDLE: begin
        bus.pkt_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      HEAD: issue_head = has_credit;
      BODY: begin
        bus.pl_ready = has_credit;
        issue_body   = bus.pl_valid && has_credit;
      end
      default: bus.busy = 1'b1;
    endcase
  end

  // Head flit assembled from the latched descriptor.
  always_comb begin
    head_flit                   = '0;
    head_flit[DST_MSB:DST_LSB]  = dst_q;
    head_flit[HEAD_BIT]         = 1'b1;
    head_flit[LEN_MSB:LEN_LSB]  = len_q;
  end

  // Descriptor latch, payload countdown and registered flit output (holds when idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q          <= '0;
      len_q          <= '0;
      remaining      <= '0;
      bus.flit_out   <= '0;
      bus.flit_write <= 1'b0;
    end else begin
      bus.flit_write <= issue;
      if ((state == IDLE) && bus.pkt_valid) begin
        dst_q     <= bus.pkt_dst;
        len_q     <= len_eff;
        remaining <= len_eff;
      end
      if (issue_head) begin
        bus.flit_out <= head_flit;
      end else if (issue_body) begin
        bus.flit_out <= bus.pl_data;
        remaining    <= remaining - 1'b1;
      end
    end
  end

`ifdef NI_PKT_CNT_EN
  logic pkt_done;
  assign pkt_done = (issue_head && (len_q == '0)) ||
                    (issue_body && (remaining == LEN_W'(1)));

  // Completed-packet counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)           bus.pkt_count <= '0;
    else if (pkt_done) bus.pkt_count <= bus.pkt_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_noc_local_packetizer.sv
// Directed bench for noc_local_packetizer: flit sequences, credit stalls, clamping, reset abandon.
// Latency: n/a.
// Backpressure: bench returns credits manually or by echoing flit_write.
module tb_noc_local_packetizer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_local_packetizer_if bus ();

  noc_local_packetizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  logic [7:0]  fq[$];
  int          fc[$];
  logic        cr_man  = 1'b0;
  logic        cr_auto = 1'b0;
  logic        auto_en = 1'b0;
  logic        saw_pl_ready = 1'b0;
  int          hs;
  int          c0;

  assign bus.credit_in = cr_man | cr_auto;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) cr_auto <= auto_en && bus.flit_write;

  // Capture every written flit with the edge count that produced it.
  always @(negedge clk) begin
    if (bus.flit_write) begin
      fq.push_back(bus.flit_out);
      fc.push_back(cyc);
    end
    if (bus.pl_ready) saw_pl_ready = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [3:0] dst, input logic [2:0] len, output int hs_cyc);
    int b;
    b = 0;
    bus.pkt_dst   = dst;
    bus.pkt_len   = len;
    bus.pkt_valid = 1'b1;
    while (!bus.pkt_ready && b < 50) begin tick(); b++; end
    if (!bus.pkt_ready) chk("pkt_hs_timeout", {31'b0, bus.pkt_ready}, 32'd1);
    tick();
    hs_cyc        = cyc;
    bus.pkt_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    int b;
    b = 0;
    bus.pl_valid = 1'b1;
    bus.pl_data  = d;
    while (!bus.pl_ready && b < 50) begin tick(); b++; end
    if (!bus.pl_ready) chk("pl_hs_timeout", {31'b0, bus.pl_ready}, 32'd1);
    tick();
    bus.pl_valid = 1'b0;
  endtask

  task automatic pulse_credit(input int n);
    for (int i = 0; i < n; i++) begin
      cr_man = 1'b1;
      tick();
      cr_man = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.pkt_dst   = '0;
    bus.pkt_len   = '0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = '0;
    repeat (2) tick();

    // reset state
    chk("rst_busy",       {31'b0, bus.busy},       32'd0);
    chk("rst_pkt_ready",  {31'b0, bus.pkt_ready},  32'd1);
    chk("rst_pl_ready",   {31'b0, bus.pl_ready},   32'd0);
    chk("rst_flit_write", {31'b0, bus.flit_write}, 32'd0);
    chk("rst_flit_out",   {24'b0, bus.flit_out},   32'h0);
    chk("rst_credit",     {29'b0, dut.credit_cnt}, 32'd4);
    rst = 1'b0;
    tick();

    // basic packet: dst=0110 len=2 -> 6A, A5, 3C back to back
    fq.delete(); fc.delete();
    send_desc(4'b0110, 3'd2, hs);
    send_word(8'hA5);
    send_word(8'h3C);
    repeat (3) tick();
    chk("t1_nflits", fq.size(), 32'd3);
    if (fq.size() >= 3) begin
      chk("t1_head", {24'b0, fq[0]}, 32'h6A);
      chk("t1_pl0",  {24'b0, fq[1]}, 32'hA5);
      chk("t1_pl1",  {24'b0, fq[2]}, 32'h3C);
      chk("t1_head_lat", fc[0], hs + 1);
      chk("t1_b2b0", fc[1], fc[0] + 1);
      chk("t1_b2b1", fc[2], fc[1] + 1);
    end
    chk("t1_credit", {29'b0, dut.credit_cnt}, 32'd1);
    chk("t1_idle",   {31'b0, bus.busy},       32'd0);
    chk("t1_hold",   {24'b0, bus.flit_out},   32'h3C);

    // refill, then surplus credits at full
    pulse_credit(3);
    chk("t3_refill",  {29'b0, dut.credit_cnt}, 32'd4);
    pulse_credit(5);
    chk("t3_surplus", {29'b0, dut.credit_cnt}, 32'd4);

    // len=3 drains all credits, second packet stalls in HEAD
    fq.delete(); fc.delete();
    send_desc(4'b0001, 3'd3, hs);
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    repeat (2) tick();
    chk("t2_nflits_a", fq.size(), 32'd4);
    chk("t2_credit0",  {29'b0, dut.credit_cnt}, 32'd0);
    send_desc(4'b1001, 3'd1, hs);
    repeat (4) tick();
    chk("t2_stall_busy",  {31'b0, bus.busy},     32'd1);
    chk("t2_stall_plrdy", {31'b0, bus.pl_ready}, 32'd0);
    chk("t2_stall_noflit", fq.size(), 32'd4);
    c0 = cyc;
    pulse_credit(1);
    repeat (3) tick();
    chk("t2_nflits_b", fq.size(), 32'd5);
    if (fq.size() >= 5) begin
      chk("t2_head2",     {24'b0, fq[4]}, 32'h99);
      chk("t2_head2_cyc", fc[4], c0 + 2);
    end
    chk("t2_credit_after_head2", {29'b0, dut.credit_cnt}, 32'd0);
    pulse_credit(1);
    send_word(8'h5A);
    repeat (2) tick();
    chk("t2_nflits_c", fq.size(), 32'd6);
    if (fq.size() >= 6) chk("t2_pl", {24'b0, fq[5]}, 32'h5A);
    chk("t2_idle", {31'b0, bus.busy}, 32'd0);

    // len=0 with credit_in coincident with the head issue at credit_cnt=2
    pulse_credit(2);
    chk("t3_pre", {29'b0, dut.credit_cnt}, 32'd2);
    fq.delete(); fc.delete();
    saw_pl_ready = 1'b0;
    send_desc(4'hF, 3'd0, hs);
    cr_man = 1'b1;
    tick();
    cr_man = 1'b0;
    repeat (3) tick();
    chk("t3_simul_credit", {29'b0, dut.credit_cnt}, 32'd2);
    chk("t4_len0_nflits", fq.size(), 32'd1);
    if (fq.size() >= 1) chk("t4_len0_head", {24'b0, fq[0]}, 32'hF8);
    chk("t4_len0_idle",   {31'b0, bus.busy},     32'd0);
    chk("t4_len0_noplrdy", {31'b0, saw_pl_ready}, 32'd0);

    // len=7 clamps to 4; router pops each flit shortly after it lands
    auto_en = 1'b1;
    fq.delete(); fc.delete();
    send_desc(4'b0011, 3'd7, hs);
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    send_word(8'h44);
    bus.pl_valid = 1'b1;
    bus.pl_data  = 8'h55;
    repeat (6) tick();
    chk("t4_clamp_plrdy", {31'b0, bus.pl_ready}, 32'd0);
    chk("t4_clamp_idle",  {31'b0, bus.busy},     32'd0);
    bus.pl_valid = 1'b0;
    auto_en = 1'b0;
    repeat (4) tick();
    chk("t4_clamp_nflits", fq.size(), 32'd5);
    if (fq.size() >= 5) begin
      chk("t4_clamp_head", {24'b0, fq[0]}, 32'h3C);
      chk("t4_clamp_last", {24'b0, fq[4]}, 32'h44);
    end
    chk("t4_credit_return", {29'b0, dut.credit_cnt}, 32'd2);

`ifdef NI_PKT_CNT_EN
    chk("pkt_count", {16'b0, bus.pkt_count}, 32'd5);
`endif

    // reset in BODY after 1 of 3 payload words
    pulse_credit(2);
    chk("t5_pre_credit", {29'b0, dut.credit_cnt}, 32'd4);
    fq.delete(); fc.delete();
    send_desc(4'b0010, 3'd3, hs);
    send_word(8'h71);
    bus.pl_valid = 1'b1;
    bus.pl_data  = 8'h72;
    rst = 1'b1;
    tick();
    chk("t5_busy",       {31'b0, bus.busy},       32'd0);
    chk("t5_flit_write", {31'b0, bus.flit_write}, 32'd0);
    chk("t5_credit",     {29'b0, dut.credit_cnt}, 32'd4);
    chk("t5_pkt_ready",  {31'b0, bus.pkt_ready},  32'd1);
    chk("t5_pl_ready",   {31'b0, bus.pl_ready},   32'd0);
    rst = 1'b0;
    repeat (5) tick();
    bus.pl_valid = 1'b0;
    chk("t5_nflits", fq.size(), 32'd2);
    if (fq.size() >= 2) chk("t5_last", {24'b0, fq[1]}, 32'h71);
`ifdef NI_PKT_CNT_EN
    chk("t5_pkt_count_rst", {16'b0, bus.pkt_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
